// File: rtl/mem_copy_master_if.sv
// Bus between an initiator and the lab memory/IO decode.
// Command encodings: MNONE=2'b00, MREAD=2'b01, MWRITE=2'b10.
// Bus ownership: the initiator may start one word only after it has seen
// grant=1 in its request cycle. Once a word has started, it runs to completion
// regardless of grant. read_data is valid in the second of the two MREAD cycles.
interface mem_copy_master_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 16
);
    logic [1:0]        mem_cmd;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] write_data;
    logic [DATA_W-1:0] read_data;
    logic              grant;

    modport master (
        output mem_cmd,
        output mem_addr,
        output write_data,
        input  read_data,
        input  grant
    );

    modport slave (
        input  mem_cmd,
        input  mem_addr,
        input  write_data,
        output read_data,
        output grant
    );
endinterface

// File: rtl/mem_copy_master.sv
// Block copy / constant fill bus initiator for the lab memory bus.
// Every output comes from a register, so nothing passes combinationally from an
// input to an output. In copy mode the write_data register also acts as the
// data buffer: read_data is captured straight into it on the edge that leaves
// RD_DATA, and it is then driven during WR.
module mem_copy_master #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 16,
    parameter int LEN_W  = 9
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              fill,
    input  logic [ADDR_W-1:0] src,
    input  logic [ADDR_W-1:0] dst,
    input  logic [LEN_W-1:0]  len,
    input  logic [DATA_W-1:0] fill_data,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic [LEN_W-1:0]  words_done,
    output logic [2:0]        dbg_state,
    mem_copy_master_if.master bus
);

    localparam logic [1:0] MNONE  = 2'b00;
    localparam logic [1:0] MREAD  = 2'b01;
    localparam logic [1:0] MWRITE = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_REQ     = 3'd1,
        S_RD_ADDR = 3'd2,
        S_RD_DATA = 3'd3,
        S_WR      = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t            r_state;
    logic              r_fill;
    logic [ADDR_W-1:0] r_src;
    logic [ADDR_W-1:0] r_dst;
    logic [LEN_W-1:0]  r_remain;
    logic [DATA_W-1:0] r_fill_data;
    logic [1:0]        r_mem_cmd;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_write_data;
    logic              r_busy;
    logic              r_done;
    logic [LEN_W-1:0]  r_words_done;

    // Per-word bookkeeping applied on the edge that ends a WR cycle.
    logic [ADDR_W-1:0] w_src_next;
    logic [ADDR_W-1:0] w_dst_next;
    logic [LEN_W-1:0]  w_remain_next;
    logic [LEN_W-1:0]  w_words_next;
    logic              w_last_word;

    assign w_src_next    = r_src + ADDR_W'(1);
    assign w_dst_next    = r_dst + ADDR_W'(1);
    assign w_remain_next = r_remain - LEN_W'(1);
    assign w_words_next  = r_words_done + LEN_W'(1);
    assign w_last_word   = (r_remain == LEN_W'(1));

    assign bus.mem_cmd    = r_mem_cmd;
    assign bus.mem_addr   = r_mem_addr;
    assign bus.write_data = r_write_data;
    assign busy           = r_busy;
    assign done           = r_done;
    assign words_done     = r_words_done;
    assign dbg_state      = r_state;

    // Transfer FSM; outputs are loaded together with the state they belong to.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_fill       <= 1'b0;
            r_src        <= '0;
            r_dst        <= '0;
            r_remain     <= '0;
            r_fill_data  <= '0;
            r_mem_cmd    <= MNONE;
            r_mem_addr   <= '0;
            r_write_data <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_words_done <= '0;
        end else begin
            // done is a single-cycle pulse, only raised on entry to DONE.
            r_done <= 1'b0;

            if (r_state == S_IDLE) begin
                // abort has no meaning here; start alone decides.
                if (start) begin
                    r_fill       <= fill;
                    r_src        <= src;
                    r_dst        <= dst;
                    r_remain     <= len;
                    r_fill_data  <= fill_data;
                    r_words_done <= '0;
                    r_busy       <= 1'b1;
                    r_mem_cmd    <= MNONE;
                    if (len == '0) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_state <= S_REQ;
                    end
                end
            end else if (abort) begin
                // A write already on the bus this cycle lands on this edge,
                // so it is counted before dropping back to IDLE.
                if (r_state == S_WR) begin
                    r_src        <= w_src_next;
                    r_dst        <= w_dst_next;
                    r_remain     <= w_remain_next;
                    r_words_done <= w_words_next;
                end
                r_state   <= S_IDLE;
                r_mem_cmd <= MNONE;
                r_busy    <= 1'b0;
            end else begin
                case (r_state)
                    S_REQ: begin
                        if (bus.grant) begin
                            if (r_fill) begin
                                r_state      <= S_WR;
                                r_mem_cmd    <= MWRITE;
                                r_mem_addr   <= r_dst;
                                r_write_data <= r_fill_data;
                            end else begin
                                r_state    <= S_RD_ADDR;
                                r_mem_cmd  <= MREAD;
                                r_mem_addr <= r_src;
                            end
                        end
                    end
                    S_RD_ADDR: begin
                        // Second MREAD cycle keeps the same command and address.
                        r_state <= S_RD_DATA;
                    end
                    S_RD_DATA: begin
                        r_state      <= S_WR;
                        r_mem_cmd    <= MWRITE;
                        r_mem_addr   <= r_dst;
                        r_write_data <= bus.read_data;
                    end
                    S_WR: begin
                        r_src        <= w_src_next;
                        r_dst        <= w_dst_next;
                        r_remain     <= w_remain_next;
                        r_words_done <= w_words_next;
                        r_mem_cmd    <= MNONE;
                        if (w_last_word) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_REQ;
                        end
                    end
                    S_DONE: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                    default: begin
                        r_state   <= S_IDLE;
                        r_mem_cmd <= MNONE;
                        r_busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mem_copy_master.sv
// Directed bench for mem_copy_master with a synchronous-read RAM model and an
// LED register at 0x100. Cycle n is the cycle after edge n-1; edge 0 samples start.
module tb_mem_copy_master;

    localparam int AW = 9;
    localparam int DW = 16;
    localparam int LW = 9;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT ----------------
    logic          start     = 1'b0;
    logic          fill      = 1'b0;
    logic [AW-1:0] src       = '0;
    logic [AW-1:0] dst       = '0;
    logic [LW-1:0] len       = '0;
    logic [DW-1:0] fill_data = '0;
    logic          abort     = 1'b0;
    logic          busy;
    logic          done;
    logic [LW-1:0] words_done;
    logic [2:0]    dbg_state;

    mem_copy_master_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_copy_master #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .fill       (fill),
        .src        (src),
        .dst        (dst),
        .len        (len),
        .fill_data  (fill_data),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .words_done (words_done),
        .dbg_state  (dbg_state),
        .bus        (bus)
    );

    // ---------------- RAM / LED model ----------------
    logic [DW-1:0] mem [0:511];
    logic          pl_en   = 1'b0;
    logic [AW-1:0] pl_addr = '0;
    logic [DW-1:0] pl_data = '0;
    int            wr_total = 0;
    logic [AW-1:0] wr_addr_log [0:255];
    logic [DW-1:0] wr_data_log [0:255];
    logic [7:0]    ledr = 8'h00;

    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        if (bus.mem_cmd == 2'b01) bus.read_data <= mem[bus.mem_addr];
        if (bus.mem_cmd == 2'b10) begin
            mem[bus.mem_addr]            <= bus.write_data;
            wr_addr_log[wr_total[7:0]]   <= bus.mem_addr;
            wr_data_log[wr_total[7:0]]   <= bus.write_data;
            wr_total                     <= wr_total + 1;
            if (bus.mem_addr == 9'h100) ledr <= bus.write_data[7:0];
        end
    end

    // ---------------- trace and knobs ----------------
    int         cyc       = 0;
    int         stall_lo  = 0;
    int         stall_hi  = -1;
    int         abort_cyc = -1;
    int         wr_base   = 0;
    logic [1:0]    t_cmd   [0:63];
    logic [AW-1:0] t_addr  [0:63];
    logic          t_busy  [0:63];
    logic          t_done  [0:63];
    logic [LW-1:0] t_words [0:63];
    logic [2:0]    t_state [0:63];

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [AW+DW-1:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        pl_en   = 1'b1;
        pl_addr = a;
        pl_data = d;
        @(posedge clk);
        #1 pl_en = 1'b0;
    endtask

    task automatic set_knobs(input int lo, input int hi, input int ab);
        stall_lo  = lo;
        stall_hi  = hi;
        abort_cyc = ab;
    endtask

    task automatic kick(input logic f, input logic [AW-1:0] s, input logic [AW-1:0] d,
                        input logic [LW-1:0] l, input logic [DW-1:0] fd);
        @(negedge clk);
        bus.grant = 1'b1;
        abort     = 1'b0;
        fill      = f;
        src       = s;
        dst       = d;
        len       = l;
        fill_data = fd;
        start     = 1'b1;
        wr_base   = wr_total;
        @(posedge clk);
        #1 start = 1'b0;
        cyc = 0;
    endtask

    // Sample outputs mid-cycle, then set grant/abort for the edge ending this cycle.
    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cyc++;
            t_cmd[cyc]   = bus.mem_cmd;
            t_addr[cyc]  = bus.mem_addr;
            t_busy[cyc]  = busy;
            t_done[cyc]  = done;
            t_words[cyc] = words_done;
            t_state[cyc] = dbg_state;
            bus.grant = !(cyc >= stall_lo && cyc <= stall_hi);
            abort     = (cyc == abort_cyc);
        end
    endtask

    function automatic logic any_done(input int lo, input int hi);
        logic r = 1'b0;
        for (int i = lo; i <= hi; i++) r = r | t_done[i];
        return r;
    endfunction

    function automatic logic any_cmd(input int lo, input int hi);
        logic r = 1'b0;
        for (int i = lo; i <= hi; i++) r = r | (t_cmd[i] != 2'b00);
        return r;
    endfunction

    task automatic check_writes(input string tag);
        int k = 0;
        check({tag, "_wr_count"}, wr_total - wr_base, exp_q.size());
        while (exp_q.size() > 0) begin
            logic [AW+DW-1:0] e = exp_q.pop_front();
            logic [AW-1:0] a = wr_addr_log[(wr_base + k) % 256];
            logic [DW-1:0] dd = wr_data_log[(wr_base + k) % 256];
            check({tag, "_wr"}, {a, dd}, e);
            k++;
        end
    endtask

    // ---------------- directed tests ----------------
    initial begin
        bus.grant = 1'b1;

        // Reset state
        #12;
        check("rst_cmd",   bus.mem_cmd,    2'b00);
        check("rst_addr",  bus.mem_addr,   9'h000);
        check("rst_wdata", bus.write_data, 16'h0000);
        check("rst_busy",  busy,           1'b0);
        check("rst_done",  done,           1'b0);
        check("rst_words", words_done,     9'd0);
        check("rst_state", dbg_state,      3'd0);
        @(negedge clk);
        reset = 1'b1;

        preload(9'h010, 16'hA1B2);
        preload(9'h011, 16'h0003);
        preload(9'h012, 16'hFFFF);

        // Copy 3 words 0x10 -> 0x40
        set_knobs(0, -1, -1);
        kick(1'b0, 9'h010, 9'h040, 9'd3, 16'h0000);
        run_cycles(14);
        check("t1_busy_c1",  t_busy[1],  1'b1);
        check("t1_busy_c13", t_busy[13], 1'b1);
        check("t1_busy_c14", t_busy[14], 1'b0);
        check("t1_rd_cmd",   t_cmd[2],   2'b01);
        check("t1_rd_addr",  t_addr[2],  9'h010);
        check("t1_rd_cmd3",  t_cmd[3],   2'b01);
        check("t1_wr_cmd",   t_cmd[4],   2'b10);
        check("t1_wr_addr",  t_addr[4],  9'h040);
        check("t1_req_cmd",  t_cmd[5],   2'b00);
        check("t1_words_c5", t_words[5], 9'd1);
        check("t1_done_c12", t_done[12], 1'b0);
        check("t1_done_c13", t_done[13], 1'b1);
        check("t1_words",    t_words[14], 9'd3);
        check("t1_mem40",    mem[9'h040], 16'hA1B2);
        check("t1_mem41",    mem[9'h041], 16'h0003);
        check("t1_mem42",    mem[9'h042], 16'hFFFF);
        exp_q.push_back({9'h040, 16'hA1B2});
        exp_q.push_back({9'h041, 16'h0003});
        exp_q.push_back({9'h042, 16'hFFFF});
        check_writes("t1");

        // Fill LED register
        set_knobs(0, -1, -1);
        kick(1'b1, 9'h000, 9'h100, 9'd1, 16'h005A);
        run_cycles(4);
        check("t2_req_cmd", t_cmd[1],  2'b00);
        check("t2_wr_cmd",  t_cmd[2],  2'b10);
        check("t2_wr_addr", t_addr[2], 9'h100);
        check("t2_done_c3", t_done[3], 1'b1);
        check("t2_ledr",    ledr,      8'h5A);
        exp_q.push_back({9'h100, 16'h005A});
        check_writes("t2");

        // Grant stall in cycles 5..7
        set_knobs(5, 7, -1);
        kick(1'b0, 9'h010, 9'h060, 9'd2, 16'h0000);
        run_cycles(13);
        check("t3_stall_none", any_cmd(5, 8), 1'b0);
        check("t3_rd2_c9",   t_cmd[9],   2'b01);
        check("t3_rd2_addr", t_addr[9],  9'h011);
        check("t3_wr2_c11",  t_cmd[11],  2'b10);
        check("t3_done_c11", t_done[11], 1'b0);
        check("t3_done_c12", t_done[12], 1'b1);
        check("t3_mem61",    mem[9'h061], 16'h0003);
        exp_q.push_back({9'h060, 16'hA1B2});
        exp_q.push_back({9'h061, 16'h0003});
        check_writes("t3");

        // Abort during the third write of an 8-word fill
        set_knobs(0, -1, 6);
        kick(1'b1, 9'h000, 9'h020, 9'd8, 16'h1234);
        run_cycles(12);
        check("t4_wr_c6",    t_cmd[6],    2'b10);
        check("t4_words",    t_words[7],  9'd3);
        check("t4_busy_c7",  t_busy[7],   1'b0);
        check("t4_state_c7", t_state[7],  3'd0);
        check("t4_idle_cmd", any_cmd(7, 12), 1'b0);
        check("t4_no_done",  any_done(1, 12), 1'b0);
        exp_q.push_back({9'h020, 16'h1234});
        exp_q.push_back({9'h021, 16'h1234});
        exp_q.push_back({9'h022, 16'h1234});
        check_writes("t4");

        // Address wrap
        set_knobs(0, -1, -1);
        kick(1'b1, 9'h000, 9'h1FF, 9'd2, 16'hBEEF);
        run_cycles(6);
        check("t5_wr0_addr", t_addr[2], 9'h1FF);
        check("t5_wr1_addr", t_addr[4], 9'h000);
        check("t5_done_c5",  t_done[5], 1'b1);
        exp_q.push_back({9'h1FF, 16'hBEEF});
        exp_q.push_back({9'h000, 16'hBEEF});
        check_writes("t5");

        // Zero length
        set_knobs(0, -1, -1);
        kick(1'b0, 9'h010, 9'h070, 9'd0, 16'h0000);
        run_cycles(3);
        check("t6_done_c1", t_done[1], 1'b1);
        check("t6_busy_c1", t_busy[1], 1'b1);
        check("t6_done_c2", t_done[2], 1'b0);
        check("t6_no_cmd",  any_cmd(1, 3), 1'b0);
        check("t6_words",   t_words[1], 9'd0);
        check_writes("t6");

        // Asynchronous reset in the middle of a copy
        set_knobs(0, -1, -1);
        kick(1'b0, 9'h010, 9'h080, 9'd2, 16'h0000);
        run_cycles(3);
        check("t7_pre_cmd",  t_cmd[3],  2'b01);
        check("t7_pre_busy", t_busy[3], 1'b1);
        #2 reset = 1'b0;
        #1;
        check("t7_rst_cmd",   bus.mem_cmd, 2'b00);
        check("t7_rst_busy",  busy,        1'b0);
        check("t7_rst_words", words_done,  9'd0);
        check("t7_rst_state", dbg_state,   3'd0);
        @(negedge clk);
        reset = 1'b1;
        kick(1'b0, 9'h012, 9'h090, 9'd1, 16'h0000);
        run_cycles(6);
        check("t7_done_c5", t_done[5], 1'b1);
        check("t7_words",   t_words[6], 9'd1);
        check("t7_mem90",   mem[9'h090], 16'hFFFF);
        exp_q.push_back({9'h090, 16'hFFFF});
        check_writes("t7");

        // ---------------- report ----------------
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
